// File: rtl/decode_in_feeder_pkg.sv
// Shared types and constants for the LC3 decode input feeder.
// Holds the sequencing FSM states and the occupancy width helper.
package decode_in_feeder_pkg;

    localparam int LC3_INSTR_W = 16;
    localparam int LC3_PC_W    = 16;

    typedef enum logic [1:0] {
        S_ARM,
        S_RUN,
        S_GAP
    } feeder_state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/decode_in_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count.
// Head entry is presented combinationally on rdata.
module decode_in_fifo
    import decode_in_feeder_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide so they wrap without a compare.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/decode_in_feeder.sv
// Buffers (instruction, next-PC) pairs and issues them to LC3 decode.
// Start delay, inter-issue gaps, stall/flush and sticky or pulsed enable.
module decode_in_feeder
    import decode_in_feeder_pkg::*;
#(
    parameter int DATA_W      = LC3_INSTR_W,
    parameter int PC_W        = LC3_PC_W,
    parameter int DEPTH       = 8,
    parameter int START_DELAY = 2,
    parameter int GAP_CYCLES  = 0,
    parameter int HOLD_ENABLE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [DATA_W-1:0]        push_instr,
    input  logic [PC_W-1:0]          push_npc,
    input  logic                     stall,
    input  logic                     flush,
    output logic [DATA_W-1:0]        dout,
    output logic [PC_W-1:0]          npc_in,
    output logic                     enable_decode,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     busy
);

    localparam int CW   = cnt_w(DEPTH);
    localparam int W    = DATA_W + PC_W;
    localparam int TMAX = (START_DELAY > GAP_CYCLES) ? START_DELAY : GAP_CYCLES;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    feeder_state_e state_q;
    feeder_state_e state_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          issue;
    logic          push_acc;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W-1:0]  head;
    logic [CW-1:0] count_nxt;

    decode_in_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_acc),
        .pop   (issue),
        .flush (flush),
        .wdata ({push_instr, push_npc}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_ARM;
            tmr_q   <= TW'(START_DELAY);
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Leaving on a count of 1 makes a delay of N allow issue on edge N+1.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            S_ARM: begin
                if (tmr_q <= TW'(1)) begin
                    state_d = S_RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_RUN: begin
                if (issue && (GAP_CYCLES > 0)) begin
                    state_d = S_GAP;
                    tmr_d   = TW'(GAP_CYCLES);
                end
            end
            S_GAP: begin
                if (flush || (tmr_q <= TW'(1))) begin
                    state_d = S_RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                state_d = S_ARM;
                tmr_d   = TW'(START_DELAY);
            end
        endcase
    end

    always_comb begin
        issue    = (state_q == S_RUN) && !fifo_empty && !stall && !flush;
        push_acc = push_valid && push_ready && !fifo_full && !flush;
    end

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push_acc && !issue) begin
            count_nxt = count + CW'(1);
        end else if (issue && !push_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Ready is registered from next occupancy, so a full FIFO refuses
    // pushes even in a cycle that also pops.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout          <= '0;
            npc_in        <= '0;
            enable_decode <= 1'b0;
            push_ready    <= 1'b0;
        end else begin
            push_ready <= (count_nxt != CW'(DEPTH));
            if (issue) begin
                {dout, npc_in} <= head;
            end
            if (flush) begin
                enable_decode <= 1'b0;
            end else if (HOLD_ENABLE != 0) begin
                enable_decode <= enable_decode || issue;
            end else begin
                enable_decode <= issue;
            end
        end
    end

    assign busy = (state_q != S_RUN) || !fifo_empty;

endmodule

// File: doc/decode_in_feeder.md
Name: decode_in_feeder

Overview:
- Synthesizable, parametrised front-end that buffers (instruction, next-PC) pairs in a FIFO and issues them to the LC3 decode stage on `dout`, `npc_in` and `enable_decode`.
- Generalises the single-shot drive-after-reset behaviour into four features:
  - a configurable start delay after reset;
  - FIFO buffering with a valid/ready push port;
  - stall and flush control;
  - optional inter-issue gaps and selectable sticky/pulsed enable.
- Sits between the fetch-side source (or a testbench sequencer) and the decode DUT.

Parameters:
- DATA_W, 16, instruction width.
- PC_W, 16, next-PC width.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- START_DELAY, 2, cycles after reset release before first issue is allowed; 0 is legal.
- GAP_CYCLES, 0, idle cycles forced after each issue.
- HOLD_ENABLE, 1: 1 = `enable_decode` sticky once set; 0 = pulses only on issue cycles.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- push_valid  in  1  source offers an entry
- push_ready  out  1  FIFO can accept; registered, equals !full
- push_instr  in  DATA_W  instruction to enqueue
- push_npc  in  PC_W  next PC to enqueue
- stall  in  1  decode stage cannot accept; blocks issue
- flush  in  1  discard all queued entries
- dout  out  DATA_W  issued instruction
- npc_in  out  PC_W  issued next PC
- enable_decode  out  1  decode enable
- count  out  $clog2(DEPTH+1)  current FIFO occupancy
- busy  out  1  FSM not in S_RUN, or FIFO non-empty

Behaviour:
- **Reset values** (while `reset`=1 at posedge): `dout`=0, `npc_in`=0, `enable_decode`=0, `push_ready`=0, `count`=0, FSM=S_ARM, delay counter=START_DELAY. Reset mid-operation discards all FIFO contents.
- **FSM states and transitions**
  - S_ARM: counts down; moves to S_RUN when the counter reaches 0. With START_DELAY=0, goes to S_RUN on the first cycle after reset.
  - S_RUN: issue is allowed.
  - S_GAP: entered after an issue if GAP_CYCLES>0; stays GAP_CYCLES cycles, then returns to S_RUN.
- **Push acceptance:** a push is accepted when `push_valid` && `push_ready` && !`flush`.
  - `push_ready` is 0 while full, even if a pop happens in the same cycle. This avoids a combinational ready path.
- **Issue condition:** S_RUN && `count`>0 && !`stall` && !`flush`.
  - At that posedge: pop the head entry and register it onto `dout`/`npc_in`.
  - HOLD_ENABLE=1: `enable_decode` is set to 1 and stays 1.
  - HOLD_ENABLE=0: `enable_decode`=1 for exactly that cycle, 0 otherwise.
- **Latency:** a push accepted at edge N into an empty FIFO in S_RUN (no stall) appears on the outputs after edge N+1.
- **Non-issue cycles:** `dout`/`npc_in` hold their last value.
- **Stall:** no pop and outputs hold. With HOLD_ENABLE=0, `enable_decode`=0 during stall.
- **Simultaneous push and pop** (not full): both occur and `count` is unchanged.
- **Wrap-around:** read/write pointers are $clog2(DEPTH) bits and wrap naturally.
- **Flush** (takes priority over push, pop and stall):
  - FIFO emptied at that edge, `count`=0, push is ignored.
  - `enable_decode`=0 (the sticky enable is cleared too).
  - `dout`/`npc_in` hold.
  - From S_GAP, go to S_RUN; S_ARM is unaffected.
- **Timing:** all outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package `decode_in_feeder_pkg` holds:
  - the state enum `feeder_state_e` (S_ARM, S_RUN, S_GAP);
  - the function `cnt_w(depth)`, returning $clog2(depth+1);
  - the LC3 constants `LC3_INSTR_W`=16 and `LC3_PC_W`=16.
- One sub-module, `decode_in_fifo`: parametrised on width and depth, synchronous reset, with push/pop/flush, full/empty and count. Width = DATA_W+PC_W (instruction and PC stored concatenated).
- The top level keeps the FSM, the counters and the output registers.

Test Plan:
- **Start delay:** START_DELAY=2, one push (0x1234, 0x3001) at the first cycle after reset → `dout`=0x1234 and `npc_in`=0x3001 appear after edge 3 post-reset; `enable_decode` 0→1 on the same cycle and stays 1.
- **Fill and wrap:** DEPTH=8. Push 10 entries 0x0100..0x0109 back-to-back with `stall`=1 → `push_ready` drops after 8, `count`=8. Then release `stall` → outputs show 0x0100..0x0109 in order on consecutive cycles, `count` returns to 0.
- **Gaps and pulsed enable:** GAP_CYCLES=2, HOLD_ENABLE=0, 3 entries queued → issues on cycles t, t+3, t+6. `enable_decode` is high only on those cycles.
- **Stall mid-stream:** stall asserted for 4 cycles while 2 entries are queued → `dout` holds, `count` stays 2; the first issue is on the cycle after stall drops.
- **Flush with push:** flush and `push_valid` (0xBEEF) in the same cycle with `count`=5 → `count`=0, 0xBEEF is not issued, `enable_decode`=0, `dout` unchanged.
- **Reset mid-stream:** reset with 4 entries queued and `enable_decode`=1 → all outputs 0 the next cycle, FSM re-arms, and no old entries are issued afterward.
